instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the control decoder: turns field-level instruction requests (kind, rd, rs1, rs2, funct3, funct7, imm)
//  into 32-bit RV32I machine words and writes them sequentially into instruction memory.
//  Sits between the testbench/boot loader and the IMEM write port, producing the programs the single-cycle core fetches.
//  Kinds: R, I-ALU, LOAD, STORE, BRANCH, JAL, LUI.
// PARAMETERS
//  ADDR_W     8   IMEM word-address width; session capacity is 2**ADDR_W words
//  BASE_ADDR  0   first word address written after start
// PORTS
//  clk          in   1       rising-edge clock (only clock)
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse; opens a load session (honoured only in IDLE or ERR)
//  in_valid     in   1       request valid
//  in_ready     out  1       request accepted when in_valid & in_ready at posedge
//  in_kind      in   3       0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 illegal
//  in_rd/in_rs1/in_rs2 in 5 each  register indices
//  in_funct3    in   3       funct3 (ignored for JAL, LUI)
//  in_funct7    in   7       funct7 (R only; I-type shifts carry funct7 in imm[11:5])
//  in_imm       in   32      immediate, byte-offset form for BRANCH/JAL, full value for LUI
//  in_last      in   1       marks final request of the session
//  imem_we      out  1       IMEM write strobe, 1-cycle pulse per word
//  imem_addr    out  ADDR_W  IMEM word address
//  imem_wdata   out  32      encoded instruction
//  busy         out  1       high in LOAD and while a write is pending
//  done         out  1       1-cycle pulse at session end
//  err_illegal  out  1       sticky until next accepted start
//  word_count   out  ADDR_W+1 words written in the current session
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, count 0. Applies immediately mid-session; pending write is discarded.
//  FSM:
//   IDLE --start--> LOAD (count<=0). LOAD: in_ready=1.
//   Accept legal kind: encoded word registered; imem_we=1 next cycle at addr=(BASE_ADDR+count) mod 2**ADDR_W; count+1.
//    Latency is 1 cycle; back-to-back accepts give one write per cycle.
//   Accept with in_last, or accept of word number 2**ADDR_W:
//    -> DONE; in_ready=0; write completes; done pulses the cycle after imem_we; -> IDLE.
//   Accept of kind 7: no write, err_illegal<=1, -> ERR (in_ready=0); earlier pending write still completes.
//   ERR --start--> LOAD (clears err_illegal, count). start in LOAD/DONE is ignored.
//  Encoding, opcode per kind 0110011/0010011/0000011/0100011/1100011/1101111/0110111:
//   R: f7|rs2|rs1|f3|rd|op.  I/LOAD: imm[11:0]|rs1|f3|rd|op.  S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
//   B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.  J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
//   U: imm[31:12]|rd|op.
//   Unused imm bits and imm[0] of B/J are dropped silently; no range checking.
//  Address wraps modulo 2**ADDR_W when BASE_ADDR>0. word_count saturates at 2**ADDR_W.
// STRUCTURE
//  Shared package: opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI),
//   kind codes, FSM state encoding.
//  Sub-module: rv32_field_encoder (pure combinational kind+fields -> 32-bit word); top holds FSM, counter, output register.
// TESTING
//  1 start; R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> next cycle imem_we=1, addr 0, wdata 0x002081B3.
//  2 I-ALU rd=5 rs1=0 f3=0 imm=-1 -> 0xFFF00293; STORE rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423.
//  3 BRANCH rs1=1 rs2=2 f3=0 imm=-4 -> 0xFE208EE3; JAL rd=1 imm=8 -> 0x008000EF; LUI rd=10 imm=0x12345000 -> 0x12345537.
//  4 Four back-to-back requests, last with in_last -> addr 0,1,2,3 on consecutive cycles; done 1 cycle after 4th;
//    word_count=4; in_ready=0.
//  5 ADDR_W=2, BASE_ADDR=3, 4 requests without in_last -> addr 3,0,1,2; done; a 5th in_valid is not accepted.
//  6 Kind 7 after one legal word -> 1 write only, err_illegal=1, in_ready=0 until start.
//    rst_n low mid-session -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader.
// Holds the RV32I opcode constants, the request kind codes and the
// loader FSM state encoding. Imported by the encoder and the top.
package instr_encoder_loader_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        KIND_R      = 3'd0,
        KIND_I      = 3'd1,
        KIND_LOAD   = 3'd2,
        KIND_STORE  = 3'd3,
        KIND_BRANCH = 3'd4,
        KIND_JAL    = 3'd5,
        KIND_LUI    = 3'd6,
        KIND_ILL    = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/rv32_field_encoder.sv
// Purely combinational RV32I field packer.
// Ports:
//   kind    in  request kind (R, I-ALU, LOAD, STORE, BRANCH, JAL, LUI, illegal)
//   rd, rs1, rs2, funct3, funct7, imm   in  instruction fields
//   word    out 32-bit machine word (0 for the illegal kind)
// Immediate bits that a format cannot carry, and imm[0] of B/J offsets,
// are simply dropped; no range checking is done.
module rv32_field_encoder
    import instr_encoder_loader_pkg::*;
(
    input  kind_e       kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (kind)
            KIND_R:      word = {funct7, rs2, rs1, funct3, rd, OP_R};
            KIND_I:      word = {imm[11:0], rs1, funct3, rd, OP_I};
            KIND_LOAD:   word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            KIND_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                                 imm[4:1], imm[11], OP_BRANCH};
            KIND_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            KIND_LUI:    word = {imm[31:12], rd, OP_LUI};
            default:     word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts field-level instruction requests,
// encodes them to RV32I words and writes them sequentially into IMEM.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               opens a load session (only from IDLE or ERR)
//   in_valid/in_ready   request handshake
//   in_kind .. in_imm   request fields; in_last marks the final request
//   imem_we/addr/wdata  registered IMEM write port (one word per accept)
//   busy                session open or a write still pending
//   done                one-cycle pulse after the final write
//   err_illegal         sticky flag after an illegal kind, cleared by start
//   word_count          words written in the current session (saturating)
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_SLOT = (ADDR_W+1)'((1 << ADDR_W) - 1);

    state_e              state_reg, state_next;
    logic [ADDR_W:0]     count_reg, count_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic [31:0]         enc_word;
    logic [ADDR_W-1:0]   slot_addr;
    kind_e               kind;

    assign kind = kind_e'(in_kind);

    rv32_field_encoder u_enc (
        .kind   (kind),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (enc_word)
    );

    // Truncating add gives the modulo-2**ADDR_W wrap for non-zero bases.
    assign slot_addr = BASE + count_reg[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_next = ST_LOAD;
                    count_next = '0;
                    err_next   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (kind == KIND_ILL) begin
                        err_next   = 1'b1;
                        state_next = ST_ERR;
                    end else begin
                        we_next    = 1'b1;
                        addr_next  = slot_addr;
                        wdata_next = enc_word;
                        count_next = count_reg + 1'b1;
                        // Filling the last address ends the session so the
                        // count never exceeds the memory capacity.
                        if (in_last || (count_reg == LAST_SLOT))
                            state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // The final write is on the port during this cycle; done
                // follows it by one cycle.
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_ready    = (state_reg == ST_LOAD);
    assign busy        = (state_reg == ST_LOAD) || we_reg;
    assign imem_we     = we_reg;
    assign imem_addr   = addr_reg;
    assign imem_wdata  = wdata_reg;
    assign done        = done_reg;
    assign err_illegal = err_reg;
    assign word_count  = count_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [2:0]  in_kind;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;

    logic        in_ready, imem_we, busy, done, err_illegal;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  word_count;

    logic        in_ready2, imem_we2, busy2, done2, err_illegal2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [2:0]  word_count2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
        .done(done), .err_illegal(err_illegal), .word_count(word_count)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready2), .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we2),
        .imem_addr(imem_addr2), .imem_wdata(imem_wdata2), .busy(busy2),
        .done(done2), .err_illegal(err_illegal2), .word_count(word_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last);
        in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("[TB] t=%0t kind=%0d we=%0b addr=%0d wdata=%08h | dut2 we=%0b addr=%0d",
                 $time, k, imem_we, imem_addr, imem_wdata, imem_we2, imem_addr2);
    endtask

    task automatic chk_write(input string tag, input logic [7:0] a, input logic [31:0] w);
        chk({tag, "_we"}, 32'(imem_we), 32'd1);
        chk({tag, "_addr"}, 32'(imem_addr), 32'(a));
        chk({tag, "_wdata"}, imem_wdata, w);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, 32'(imem_we), 0);
        chk({tag, "_addr"}, 32'(imem_addr), 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err_illegal), 0);
        chk({tag, "_count"}, 32'(word_count), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_kind = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;
        in_imm = '0; in_last = 1'b0;
        step(); step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // 1: single R word
        start = 1'b1; step(); start = 1'b0;
        chk("t1_ready", 32'(in_ready), 1);
        chk("t1_busy", 32'(busy), 1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk_write("t1_r", 8'd0, 32'h002081B3);
        chk("t1_count", 32'(word_count), 1);

        // 2/3: I, STORE, BRANCH, JAL, LUI (last)
        send(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0);
        chk_write("t2_i", 8'd1, 32'hFFF00293);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
        chk_write("t2_s", 8'd2, 32'h0020A423);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0);
        chk_write("t3_b", 8'd3, 32'hFE208EE3);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0);
        chk_write("t3_j", 8'd4, 32'h008000EF);
        send(3'd6, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1);
        chk_write("t3_u", 8'd5, 32'h12345537);
        chk("t3_ready_after_last", 32'(in_ready), 0);
        step();
        chk("t3_done", 32'(done), 1);
        chk("t3_we_off", 32'(imem_we), 0);
        chk("t3_count", 32'(word_count), 6);
        step();
        chk("t3_done_pulse", 32'(done), 0);
        chk("t3_idle_busy", 32'(busy), 0);

        // 4: four back-to-back requests
        start = 1'b1; step(); start = 1'b0;
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk_write("t4_w0", 8'd0, 32'h002081B3);
        send(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0);
        chk_write("t4_w1", 8'd1, 32'hFFF00293);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
        chk_write("t4_w2", 8'd2, 32'h0020A423);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1);
        chk_write("t4_w3", 8'd3, 32'hFE208EE3);
        chk("t4_ready", 32'(in_ready), 0);
        chk("t4_busy", 32'(busy), 1);
        step();
        chk("t4_done", 32'(done), 1);
        chk("t4_count", 32'(word_count), 4);
        chk("t4_ready_done", 32'(in_ready), 0);
        step();
        chk("t4_done_pulse", 32'(done), 0);

        // 6: illegal kind after one legal word
        start = 1'b1; step(); start = 1'b0;
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk_write("t6_legal", 8'd0, 32'h002081B3);
        send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("t6_no_write", 32'(imem_we), 0);
        chk("t6_err", 32'(err_illegal), 1);
        chk("t6_ready", 32'(in_ready), 0);
        chk("t6_count", 32'(word_count), 1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("t6_err_blocked", 32'(imem_we), 0);
        chk("t6_err_sticky", 32'(err_illegal), 1);
        start = 1'b1; step(); start = 1'b0;
        chk("t6_err_clr", 32'(err_illegal), 0);
        chk("t6_count_clr", 32'(word_count), 0);
        chk("t6_ready_again", 32'(in_ready), 1);

        // 6b: asynchronous reset with a write on the port
        send(3'd6, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
        chk_write("t6r_pre", 8'd0, 32'h12345537);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("t6r_async");
        step();
        rst_n = 1'b1;
        step();

        // 5: ADDR_W=2, BASE_ADDR=3 wraps and saturates without in_last
        start = 1'b1; step(); start = 1'b0;
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("t5_a0", 32'(imem_addr2), 3);
        chk("t5_w0", imem_wdata2, 32'h002081B3);
        send(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0);
        chk("t5_a1", 32'(imem_addr2), 0);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
        chk("t5_a2", 32'(imem_addr2), 1);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0);
        chk("t5_a3", 32'(imem_addr2), 2);
        chk("t5_we3", 32'(imem_we2), 1);
        chk("t5_wdata3", imem_wdata2, 32'hFE208EE3);
        chk("t5_ready", 32'(in_ready2), 0);
        chk("t5_count", 32'(word_count2), 4);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("t5_fifth_rejected", 32'(imem_we2), 0);
        chk("t5_done", 32'(done2), 1);
        step();
        chk("t5_done_pulse", 32'(done2), 0);
        chk("t5_count_sat", 32'(word_count2), 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
